// File: rtl/vr8_prior_pkg.sv
// Shared constants and golden priority-index helper for the vr8 priority encoder.
package vr8_prior_pkg;

    localparam int N_DEF  = 8;
    localparam int AW_DEF = 3;

    // Index of the highest set bit of vec; 0 when vec is all zeros.
    function automatic int prior_idx(input logic [31:0] vec);
        int idx;
        idx = 0;
        for (int k = 0; k < 32; k++) begin
            if (vec[k]) begin
                idx = k;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/vr8_prior_core.sv
// Combinational priority encoder core: highest set request bit -> index,
// idle flag and (with VR8_PRIOR_ONEHOT_EN) a one-hot grant vector.
module vr8_prior_core
    import vr8_prior_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int AW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    output logic [AW-1:0] a_next,
    output logic          idle_next
`ifdef VR8_PRIOR_ONEHOT_EN
    ,
    output logic [N-1:0]  gnt_next
`endif
);

    // hi_any[k] is set when any request at index k or above is active;
    // hi_any[N] is the empty range above the top bit.
    logic [N:0]   hi_any;
    logic [N-1:0] onehot;

    assign hi_any[N] = 1'b0;

    genvar gi;
    generate
        for (gi = N - 1; gi >= 0; gi--) begin : g_scan
            assign hi_any[gi] = hi_any[gi+1] | req[gi];
            // A bit wins only if nothing above it is requesting.
            assign onehot[gi] = req[gi] & ~hi_any[gi+1];
        end
    endgenerate

    assign idle_next = ~hi_any[0];

    // Binary-encode the one-hot winner; an all-zero vector encodes to 0.
    always_comb begin
        a_next = '0;
        for (int k = 0; k < N; k++) begin
            if (onehot[k]) begin
                a_next = a_next | AW'(k);
            end
        end
    end

`ifdef VR8_PRIOR_ONEHOT_EN
    assign gnt_next = onehot;
`endif

endmodule

// File: rtl/vr8_in_prior3.sv
// Registered N-input priority encoder (default N=8). A holds the index of the
// highest asserted request, IDLE flags an all-zero sample. One cycle latency,
// sample enable en, synchronous active-high reset rst.
// Optional macro VR8_PRIOR_ONEHOT_EN adds a registered one-hot grant port GNT.
module vr8_in_prior3
    import vr8_prior_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [N-1:0]  I,
    output logic [AW-1:0] A,
    output logic          IDLE
`ifdef VR8_PRIOR_ONEHOT_EN
    ,
    output logic [N-1:0]  GNT
`endif
);

    logic [AW-1:0] a_next;
    logic          idle_next;
    logic [AW-1:0] a_reg;
    logic          idle_reg;

`ifdef VR8_PRIOR_ONEHOT_EN
    logic [N-1:0]  gnt_next;
    logic [N-1:0]  gnt_reg;
`endif

    vr8_prior_core #(
        .N  (N),
        .AW (AW)
    ) u_core (
        .req       (I),
        .a_next    (a_next),
        .idle_next (idle_next)
`ifdef VR8_PRIOR_ONEHOT_EN
        ,
        .gnt_next  (gnt_next)
`endif
    );

    // Output register: reset wins over enable; en low holds all outputs together.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg    <= '0;
            idle_reg <= 1'b1;
        end else if (en) begin
            a_reg    <= a_next;
            idle_reg <= idle_next;
        end
    end

`ifdef VR8_PRIOR_ONEHOT_EN
    // Grant register shares the reset and enable behaviour of A.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_reg <= '0;
        end else if (en) begin
            gnt_reg <= gnt_next;
        end
    end

    assign GNT = gnt_reg;
`endif

    assign A    = a_reg;
    assign IDLE = idle_reg;

endmodule

// File: tb/tb_vr8_in_prior3.sv
// Scoreboard bench for vr8_in_prior3: the driver pushes the expected result of
// each sampled cycle, a separate monitor pops and compares one cycle later.
// Build with +define+VR8_PRIOR_ONEHOT_EN to also check GNT.
module tb_vr8_in_prior3;
    import vr8_prior_pkg::*;

    localparam int N  = N_DEF;
    localparam int AW = AW_DEF;

    logic          clk;
    logic          rst;
    logic          en;
    logic [N-1:0]  i_vec;
    logic [AW-1:0] a;
    logic          idle;
`ifdef VR8_PRIOR_ONEHOT_EN
    logic [N-1:0]  gnt;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    // mode 0: exact expected values; mode 1: range invariant against stim
    typedef struct {
        int            mode;
        logic [N-1:0]  stim;
        logic [AW-1:0] a;
        logic          idle;
        logic [N-1:0]  gnt;
        string         name;
    } exp_t;

    exp_t sb_q[$];

    vr8_in_prior3 #(.N(N), .AW(AW)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .I    (i_vec),
        .A    (a),
        .IDLE (idle)
`ifdef VR8_PRIOR_ONEHOT_EN
        ,
        .GNT  (gnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic r, input logic e, input logic [N-1:0] v,
                         input int mode, input logic [AW-1:0] ea,
                         input logic eidle, input logic [N-1:0] egnt,
                         input string nm);
        exp_t x;
        @(negedge clk);
        rst   = r;
        en    = e;
        i_vec = v;
        x.mode = mode;
        x.stim = v;
        x.a    = ea;
        x.idle = eidle;
        x.gnt  = egnt;
        x.name = nm;
        sb_q.push_back(x);
    endtask

    // Monitor: results of the inputs sampled at a rising edge appear just after it.
    initial begin
        exp_t e;
        int   lo;
        int   hi;
        logic ok;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                if (e.mode == 0) begin
                    n_checks++;
                    if (a !== e.a || idle !== e.idle) begin
                        n_fails++;
                        $display("FAIL %s: I=%h got A=%0d IDLE=%b, want A=%0d IDLE=%b",
                                 e.name, e.stim, a, idle, e.a, e.idle);
                    end
`ifdef VR8_PRIOR_ONEHOT_EN
                    n_checks++;
                    if (gnt !== e.gnt) begin
                        n_fails++;
                        $display("FAIL %s_gnt: I=%h got GNT=%h, want GNT=%h",
                                 e.name, e.stim, gnt, e.gnt);
                    end
`endif
                end else begin
                    n_checks++;
                    if (e.stim == '0) begin
                        ok = (a === '0) && (idle === 1'b1);
                    end else begin
                        lo = 1 << int'(a);
                        hi = 1 << (int'(a) + 1);
                        ok = (idle === 1'b0) && !$isunknown(a) &&
                             (lo <= int'(e.stim)) && (int'(e.stim) < hi);
                    end
                    if (!ok) begin
                        n_fails++;
                        $display("FAIL %s: I=%h got A=%0d IDLE=%b, range invariant violated",
                                 e.name, e.stim, a, idle);
                    end
`ifdef VR8_PRIOR_ONEHOT_EN
                    n_checks++;
                    if (gnt !== ((e.stim == '0) ? N'(0) : (N'(1) << a))) begin
                        n_fails++;
                        $display("FAIL %s_gnt: I=%h got GNT=%h with A=%0d",
                                 e.name, e.stim, gnt, a);
                    end
`endif
                end
                $display("txn %s I=%h A=%0d IDLE=%b", e.name, e.stim, a, idle);
            end
        end
    end

    // Absolute time bound so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, %0d expectations pending",
                 sb_q.size());
        $fatal(1, "timeout");
    end

    initial begin
        rst   = 1'b1;
        en    = 1'b0;
        i_vec = '0;

        // reset dominates a full request vector with en high
        drive(1'b1, 1'b1, 8'hFF, 0, 3'd0, 1'b1, 8'h00, "reset0");
        drive(1'b1, 1'b1, 8'hFF, 0, 3'd0, 1'b1, 8'h00, "reset1");
        drive(1'b0, 1'b1, 8'hFF, 0, 3'd7, 1'b0, 8'h80, "rst_release");

        // single-bit inputs
        drive(1'b0, 1'b1, 8'h01, 0, 3'd0, 1'b0, 8'h01, "bit0");
        drive(1'b0, 1'b1, 8'h10, 0, 3'd4, 1'b0, 8'h10, "bit4");
        drive(1'b0, 1'b1, 8'h80, 0, 3'd7, 1'b0, 8'h80, "bit7");

        // priority masking
        drive(1'b0, 1'b1, 8'b0101_1011, 0, 3'd6, 1'b0, 8'h40, "mask_5b");
        drive(1'b0, 1'b1, 8'b0000_0011, 0, 3'd1, 1'b0, 8'h02, "mask_03");

        // enable hold
        drive(1'b0, 1'b1, 8'h20, 0, 3'd5, 1'b0, 8'h20, "load_20");
        drive(1'b0, 1'b0, 8'h00, 0, 3'd5, 1'b0, 8'h20, "hold0");
        drive(1'b0, 1'b0, 8'h00, 0, 3'd5, 1'b0, 8'h20, "hold1");
        drive(1'b0, 1'b0, 8'h00, 0, 3'd5, 1'b0, 8'h20, "hold2");
        drive(1'b0, 1'b1, 8'h00, 0, 3'd0, 1'b1, 8'h00, "en_rise");

        // one-hot grant patterns
        drive(1'b0, 1'b1, 8'b0011_0100, 0, 3'd5, 1'b0, 8'h20, "gnt_34");
        drive(1'b0, 1'b1, 8'b0010_0110, 0, 3'd5, 1'b0, 8'h20, "gnt_26");
        drive(1'b0, 1'b1, 8'h00,        0, 3'd0, 1'b1, 8'h00, "gnt_zero");

        // reset wins even when en is low
        drive(1'b0, 1'b1, 8'hAA, 0, 3'd7, 1'b0, 8'h80, "load_aa");
        drive(1'b1, 1'b0, 8'hAA, 0, 3'd0, 1'b1, 8'h00, "rst_over_en");

        // exhaustive sweep checked against the power-of-two range invariant
        for (int k = 0; k < 256; k++) begin
            drive(1'b0, 1'b1, 8'(k), 1, 3'd0, 1'b0, 8'h00, "sweep");
        end

        // let the monitor drain, bounded by a few cycles
        for (int w = 0; w < 4 && sb_q.size() > 0; w++) begin
            @(negedge clk);
        end
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fails++;
            $display("FAIL drain: %0d expectations still queued, want 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/vr8_in_prior3.md
Name: vr8_in_prior3

Overview:
Registered 8-input priority encoder. It reports the index of the highest-numbered asserted request line on A. IDLE is asserted when no line is active. It is used as a request arbiter/encoder stage in front of downstream selection logic; outputs are registered for clean timing.

Parameters:
N, 8, number of request inputs (supported range 2..32).
AW, $clog2(N), width of encoded output A (3 for default).

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous active-high reset.
en  input  1  sample enable; when low, registered outputs hold.
I  input  N  request vector, bit N-1 highest priority.
A  output  AW  registered index of highest set bit of I.
IDLE  output  1  registered; 1 when sampled I == 0.

Behaviour:
- One clock; reset is synchronous and active-high (clk, rst).
- Reset: at a rising clk with rst=1, A <= 0 and IDLE <= 1, regardless of en or I. rst has priority over en.
- Encoding, combinational core:
  - a_next = largest k such that I[k]==1.
  - idle_next = (I == 0).
  - When I == 0, a_next = 0 (never X/undefined).
- Invariant for I != 0: 2**a_next <= I < 2**(a_next+1), treating I as unsigned.
- Register stage, at each rising clk with rst=0:
  - en=1: A <= a_next, IDLE <= idle_next.
  - en=0: A and IDLE hold their previous values.
- Latency: exactly 1 cycle from I/en sample to A/IDLE update. No combinational path from I to outputs.
- A and IDLE are always mutually consistent: both are loaded in the same cycle from the same sample.
- Lower-priority bits are don't-cares whenever a higher bit is set, e.g. I=8'b1111_1111 gives A=7.
- Inputs containing X/Z: behaviour unspecified. Outputs after reset must never contain X.
- No state machine; the block is a pure pipeline register over the encoder.

Optional Feature:
Macro VR8_PRIOR_ONEHOT_EN.
- Defined:
  - Adds output port GNT [N-1:0], registered with the same timing, reset and en-hold rules as A.
  - GNT = one-hot of the highest set bit of I (e.g. I=8'b0010_0110 gives GNT=8'b0010_0000).
  - GNT = 0 when idle; reset value 0.
- Undefined: port GNT absent; all other behaviour identical.

Decomposition:
- Shared package vr8_prior_pkg holds:
  - default constants N_DEF=8 and AW_DEF=3;
  - a function prior_idx(vec) returning the highest-set-bit index (0 for zero vector), reusable by the bench as a golden model.
- One natural sub-module: vr8_prior_core. It is the purely combinational encoder producing a_next, idle_next and (with the macro) gnt_next. The top level instantiates it and adds the registers, reset and enable.

Test Plan:
- Reset: rst=1 for 2 cycles with I=8'hFF, en=1 -> A=0, IDLE=1 while reset; the first cycle after release gives A=7, IDLE=0.
- Exhaustive sweep: en=1, I=0..255, one value per cycle -> each result one cycle later satisfies:
  - I==0: IDLE=1 and A=0.
  - Otherwise: IDLE=0 and 2**A <= I < 2**(A+1).
  - Zero errors over the full sweep.
- Single-bit inputs: I=8'h01, 8'h10, 8'h80 -> A=0, 4, 7 respectively, IDLE=0.
- Priority masking: I=8'b0101_1011 -> A=6; I=8'b0000_0011 -> A=1.
- Enable hold: load I=8'h20 with en=1 (A=5), then drive I=8'h00 with en=0 for 3 cycles -> A stays 5, IDLE stays 0. Raise en -> next cycle A=0, IDLE=1.
- With VR8_PRIOR_ONEHOT_EN: I=8'b0011_0100 -> GNT=8'b0010_0000; I=0 -> GNT=0; reset -> GNT=0.
